// File: rtl/rs_bm_iter.sv
// Iterative Berlekamp-Massey solver: turns 2*T_VAL syndromes into an error locator polynomial,
// one BM step per clock, fixed latency regardless of syndrome contents.
package gf_pkg;
   localparam int unsigned MaxW = 16;
   typedef logic [MaxW-1:0] gf_t;

   // Shift-and-add multiply in GF(2^w), w <= MaxW, reduced by poly (bit w set).
   function automatic gf_t gf_mul(gf_t a, gf_t b, int unsigned w, logic [MaxW:0] poly);
      logic [MaxW:0] acc;
      acc = '0;
      for (int i = MaxW - 1; i >= 0; i--) begin
         if (i < int'(w)) begin
            acc = acc << 1;
            if ((acc >> w) != '0) acc = acc ^ poly;
            if (b[i]) acc = acc ^ {1'b0, a};
         end
      end
      return acc[MaxW-1:0];
   endfunction

   // a^(2^w - 2) built as the product of a^(2^i) for i = 1..w-1.
   function automatic gf_t gf_inv(gf_t a, int unsigned w, logic [MaxW:0] poly);
      gf_t sq;
      gf_t res;
      sq  = a;
      res = gf_t'(1);
      for (int i = 1; i < int'(MaxW); i++) begin
         sq = gf_mul(sq, sq, w, poly);
         if (i < int'(w)) res = gf_mul(res, sq, w, poly);
      end
      return res;
   endfunction
endpackage

module rs_bm_iter #(
   parameter int unsigned SYMB_WIDTH = 8,
   parameter int unsigned T_VAL      = 8,
   parameter int unsigned GF_POLY    = 'h11D,
   localparam int unsigned ROOTS_NUM = 2 * T_VAL,
   localparam int unsigned LEN_W     = $clog2(ROOTS_NUM + 1)
) (
   input  logic                            aclk,
   input  logic                            aresetn,
   input  logic                            clear,
   input  logic [ROOTS_NUM*SYMB_WIDTH-1:0] syndrome,
   input  logic                            syndrome_vld,
   output logic                            syndrome_rdy,
   output logic [(T_VAL+1)*SYMB_WIDTH-1:0] err_loc,
   output logic [LEN_W-1:0]                err_loc_len,
   output logic                            err_loc_vld,
   input  logic                            err_loc_rdy,
   output logic                            decode_error
);

   typedef logic [SYMB_WIDTH-1:0] sym_t;
   typedef enum logic [1:0] {StIdle, StIter, StDone} state_e;

   localparam logic [gf_pkg::MaxW:0] Poly = GF_POLY[gf_pkg::MaxW:0];

   function automatic sym_t mul(sym_t a, sym_t b);
      return sym_t'(gf_pkg::gf_mul(gf_pkg::gf_t'(a), gf_pkg::gf_t'(b), SYMB_WIDTH, Poly));
   endfunction

   function automatic sym_t inv(sym_t a);
      return sym_t'(gf_pkg::gf_inv(gf_pkg::gf_t'(a), SYMB_WIDTH, Poly));
   endfunction

   state_e            state_q, state_d;
   sym_t              lambda_q [ROOTS_NUM+1];
   sym_t              lambda_d [ROOTS_NUM+1];
   sym_t              b_q      [ROOTS_NUM+1];
   sym_t              b_d      [ROOTS_NUM+1];
   sym_t              win_q    [ROOTS_NUM];
   sym_t              win_d    [ROOTS_NUM];
   sym_t              pend_q   [ROOTS_NUM-1];
   sym_t              pend_d   [ROOTS_NUM-1];
   logic [LEN_W-1:0]  len_q, len_d;
   logic [LEN_W-1:0]  r_q, r_d;
   logic              vld_q, vld_d;
   logic              derr_q, derr_d;

   sym_t              xb         [ROOTS_NUM+1];
   sym_t              lambda_upd [ROOTS_NUM+1];
   sym_t              delta;
   sym_t              delta_inv;
   int                deg;

   always_comb begin
      state_d   = state_q;
      lambda_d  = lambda_q;
      b_d       = b_q;
      win_d     = win_q;
      pend_d    = pend_q;
      len_d     = len_q;
      r_d       = r_q;
      vld_d     = vld_q;
      derr_d    = derr_q;
      delta     = '0;
      delta_inv = '0;
      deg       = 0;

      xb[0] = '0;
      for (int j = 1; j <= int'(ROOTS_NUM); j++) xb[j] = b_q[j-1];
      // win_q[j] already holds S(r-1-j), zero where that index would be negative.
      for (int j = 0; j < int'(ROOTS_NUM); j++) begin
         if (LEN_W'(j) <= len_q) delta = delta ^ mul(lambda_q[j], win_q[j]);
      end
      for (int j = 0; j <= int'(ROOTS_NUM); j++) lambda_upd[j] = lambda_q[j] ^ mul(delta, xb[j]);

      unique case (state_q)
         StIdle: begin
            if (syndrome_vld) begin
               lambda_d    = '{default: '0};
               lambda_d[0] = sym_t'(1);
               b_d         = '{default: '0};
               b_d[0]      = sym_t'(1);
               len_d       = '0;
               r_d         = LEN_W'(1);
               derr_d      = 1'b0;
               win_d       = '{default: '0};
               win_d[0]    = syndrome[0 +: SYMB_WIDTH];
               for (int k = 0; k < int'(ROOTS_NUM) - 1; k++) begin
                  pend_d[k] = syndrome[(k+1)*SYMB_WIDTH +: SYMB_WIDTH];
               end
               state_d     = StIter;
            end
         end
         StIter: begin
            if (delta != '0) begin
               lambda_d = lambda_upd;
               if (2 * int'(len_q) <= int'(r_q) - 1) begin
                  len_d     = r_q - len_q;
                  delta_inv = inv(delta);
                  for (int j = 0; j <= int'(ROOTS_NUM); j++) b_d[j] = mul(lambda_q[j], delta_inv);
               end else begin
                  b_d = xb;
               end
            end else begin
               b_d = xb;
            end
            win_d[0] = pend_q[0];
            for (int j = 1; j < int'(ROOTS_NUM); j++) win_d[j] = win_q[j-1];
            for (int k = 0; k < int'(ROOTS_NUM) - 2; k++) pend_d[k] = pend_q[k+1];
            pend_d[ROOTS_NUM-2] = '0;
            r_d = r_q + LEN_W'(1);
            if (r_q == LEN_W'(ROOTS_NUM)) begin
               for (int j = 0; j <= int'(ROOTS_NUM); j++) begin
                  if (lambda_d[j] != '0) deg = j;
               end
               derr_d  = (len_d > LEN_W'(T_VAL)) || (deg != int'(len_d));
               vld_d   = 1'b1;
               state_d = StDone;
            end
         end
         StDone: begin
            if (err_loc_rdy) begin
               vld_d   = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (clear) begin
         vld_d   = 1'b0;
         state_d = StIdle;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q  <= StIdle;
         lambda_q <= '{default: '0};
         b_q      <= '{default: '0};
         win_q    <= '{default: '0};
         pend_q   <= '{default: '0};
         len_q    <= '0;
         r_q      <= '0;
         vld_q    <= 1'b0;
         derr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         lambda_q <= lambda_d;
         b_q      <= b_d;
         win_q    <= win_d;
         pend_q   <= pend_d;
         len_q    <= len_d;
         r_q      <= r_d;
         vld_q    <= vld_d;
         derr_q   <= derr_d;
      end
   end

   always_comb begin
      err_loc = '0;
      for (int j = 0; j <= int'(T_VAL); j++) err_loc[j*SYMB_WIDTH +: SYMB_WIDTH] = lambda_q[j];
   end

   assign syndrome_rdy = (state_q == StIdle);
   assign err_loc_len  = len_q;
   assign err_loc_vld  = vld_q;
   assign decode_error = derr_q;

endmodule

// File: tb/tb_rs_bm_iter.sv
// Directed bench for rs_bm_iter (T_VAL=2, GF(256) poly 0x11D) with an expected-result queue.
module tb_rs_bm_iter;
   localparam int W  = 8;
   localparam int T  = 2;
   localparam int R  = 2 * T;
   localparam int LW = 3;

   typedef struct {
      logic [(T+1)*W-1:0] loc;
      logic [LW-1:0]      len;
      logic               derr;
   } exp_t;

   logic               aclk = 1'b0;
   logic               aresetn;
   logic               clear;
   logic [R*W-1:0]     syndrome;
   logic               syndrome_vld;
   logic               syndrome_rdy;
   logic [(T+1)*W-1:0] err_loc;
   logic [LW-1:0]      err_loc_len;
   logic               err_loc_vld;
   logic               err_loc_rdy;
   logic               decode_error;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;

   rs_bm_iter #(.SYMB_WIDTH(W), .T_VAL(T), .GF_POLY('h11D)) dut (
      .aclk         (aclk),
      .aresetn      (aresetn),
      .clear        (clear),
      .syndrome     (syndrome),
      .syndrome_vld (syndrome_vld),
      .syndrome_rdy (syndrome_rdy),
      .err_loc      (err_loc),
      .err_loc_len  (err_loc_len),
      .err_loc_vld  (err_loc_vld),
      .err_loc_rdy  (err_loc_rdy),
      .decode_error (decode_error)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = '0;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1D) : (aa << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] gpow(input int e);
      logic [7:0] x;
      x = 8'h01;
      for (int i = 0; i < e; i++) x = gmul(x, 8'h02);
      return x;
   endfunction

   // Syndromes from known error positions/values; lambda = prod (1 + X_k x).
   task automatic build(input int n, input int p1, input logic [7:0] e1, input int p2,
                        input logic [7:0] e2, output logic [R*W-1:0] s, output exp_t e);
      logic [7:0] x1, x2, sym;
      x1 = gpow(p1);
      x2 = gpow(p2);
      s  = '0;
      for (int i = 0; i < R; i++) begin
         sym = gmul(e1, gpow(p1 * i));
         if (n == 2) sym = sym ^ gmul(e2, gpow(p2 * i));
         s[i*W +: W] = sym;
      end
      if (n == 2) begin
         e.loc = {gmul(x1, x2), x1 ^ x2, 8'h01};
         e.len = 3'd2;
      end else begin
         e.loc = {8'h00, x1, 8'h01};
         e.len = 3'd1;
      end
      e.derr = 1'b0;
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, ".rdy"}, syndrome_rdy, 1);
      chk({tag, ".vld"}, err_loc_vld, 0);
      chk({tag, ".loc"}, err_loc, 0);
      chk({tag, ".len"}, err_loc_len, 0);
      chk({tag, ".derr"}, decode_error, 0);
   endtask

   // Returns #1 after the accepting edge, i.e. in cycle 1.
   task automatic send(input string tag, input logic [R*W-1:0] s, input bit push, input exp_t e);
      @(negedge aclk);
      syndrome     = s;
      syndrome_vld = 1'b1;
      if (push) sb.push_back(e);
      @(posedge aclk);
      #1;
      syndrome_vld = 1'b0;
      chk({tag, ".accept"}, syndrome_rdy, 0);
   endtask

   task automatic wait_result(input string tag, input bit consume);
      int   cyc;
      exp_t e;
      cyc = 1;
      while (!err_loc_vld && cyc <= 20) begin
         @(posedge aclk);
         #1;
         cyc++;
      end
      chk({tag, ".lat"}, cyc, R + 1);
      chk({tag, ".pending"}, (sb.size() > 0), 1);
      if (err_loc_vld && sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".loc"}, err_loc, e.loc);
         chk({tag, ".len"}, err_loc_len, e.len);
         chk({tag, ".derr"}, decode_error, e.derr);
      end
      if (consume) begin
         @(posedge aclk);
         #1;
         chk({tag, ".idle_vld"}, err_loc_vld, 0);
         chk({tag, ".idle_rdy"}, syndrome_rdy, 1);
      end
   endtask

   initial begin
      exp_t           e, e2;
      logic [R*W-1:0] s, s2;

      aresetn      = 1'b1;
      clear        = 1'b0;
      syndrome     = '0;
      syndrome_vld = 1'b0;
      err_loc_rdy  = 1'b1;
      #2 aresetn = 1'b0;
      #1 chk_reset("reset");
      @(negedge aclk);
      aresetn = 1'b1;

      e = '{loc: 24'h000001, len: 3'd0, derr: 1'b0};
      send("zero", 32'h00000000, 1'b1, e);
      wait_result("zero", 1'b1);

      e = '{loc: 24'h000201, len: 3'd1, derr: 1'b0};
      send("single1", 32'h08040201, 1'b1, e);
      wait_result("single1", 1'b1);

      e = '{loc: 24'h000001, len: 3'd4, derr: 1'b1};
      send("s3only", 32'h01000000, 1'b1, e);
      wait_result("s3only", 1'b1);

      e = '{loc: 24'h000001, len: 3'd1, derr: 1'b1};
      send("s0only", 32'h00000001, 1'b1, e);
      wait_result("s0only", 1'b1);

      build(2, 3, 8'h5A, 10, 8'h07, s, e);
      send("double_a", s, 1'b1, e);
      wait_result("double_a", 1'b1);

      build(2, 0, 8'hFF, 200, 8'h81, s, e);
      send("double_b", s, 1'b1, e);
      wait_result("double_b", 1'b1);

      // Hold the result in DONE, then release with a new syndrome already waiting.
      build(2, 17, 8'h21, 99, 8'hC4, s, e);
      err_loc_rdy = 1'b0;
      send("hold", s, 1'b1, e);
      wait_result("hold", 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(posedge aclk);
         #1;
         chk("hold.vld", err_loc_vld, 1);
         chk("hold.loc", err_loc, e.loc);
         chk("hold.rdy", syndrome_rdy, 0);
      end
      build(1, 77, 8'h33, 0, 8'h00, s2, e2);
      @(negedge aclk);
      err_loc_rdy  = 1'b1;
      syndrome     = s2;
      syndrome_vld = 1'b1;
      sb.push_back(e2);
      @(posedge aclk);
      #1;
      chk("b2b.idle_rdy", syndrome_rdy, 1);
      chk("b2b.idle_vld", err_loc_vld, 0);
      @(posedge aclk);
      #1;
      syndrome_vld = 1'b0;
      chk("b2b.accept", syndrome_rdy, 0);
      wait_result("b2b", 1'b1);

      // Asynchronous reset in the middle of iteration (r=2).
      build(2, 5, 8'h11, 6, 8'h22, s, e);
      send("abort_rst", s, 1'b0, e);
      @(posedge aclk);
      #2 aresetn = 1'b0;
      #1 chk_reset("midrst");
      @(negedge aclk);
      aresetn = 1'b1;

      // Synchronous clear at r=3.
      send("abort_clr", s, 1'b0, e);
      @(posedge aclk);
      #1;
      @(negedge aclk);
      clear = 1'b1;
      @(posedge aclk);
      #1;
      chk("clear.rdy", syndrome_rdy, 1);
      chk("clear.vld", err_loc_vld, 0);
      @(negedge aclk);
      clear = 1'b0;
      repeat (6) @(posedge aclk);
      #1;
      chk("clear.novld", err_loc_vld, 0);

      build(2, 40, 8'h9E, 41, 8'h01, s, e);
      send("after", s, 1'b1, e);
      wait_result("after", 1'b1);

      chk("sb.empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
